// File: rtl/wiegand_pkg.sv
// wiegand_pkg: shared widths, field positions and ID type for the Wiegand-26 decoder.
package wiegand_pkg;
  localparam int WG_FRAME_W = 26;
  localparam int WG_ID_W = 24;
  localparam int EVEN_PAR_BIT = 25;
  localparam int ODD_PAR_BIT = 0;
  localparam int EVEN_HI = 24;
  localparam int EVEN_LO = 13;
  localparam int ODD_HI = 12;
  localparam int ODD_LO = 1;
  localparam int FAC_HI = 24;
  localparam int FAC_LO = 17;
  localparam int CARD_HI = 16;
  localparam int CARD_LO = 1;
  typedef struct packed {
    logic [7:0]  facility;
    logic [15:0] card;
  } wg_id_t;
  function automatic logic parity_ok(input logic [WG_FRAME_W-1:0] f);
    return (f[EVEN_PAR_BIT] == ^f[EVEN_HI:EVEN_LO]) && (f[ODD_PAR_BIT] == ~^f[ODD_HI:ODD_LO]);
  endfunction
endpackage

// File: rtl/wg_id_fifo.sv
// wg_id_fifo: first-word-fall-through synchronous FIFO for decoded card IDs.
module wg_id_fifo
  import wiegand_pkg::*;
#(
  parameter int W = WG_ID_W,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign rd = rd_en && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the write
  assign wr = wr_en && (!full || rd);
  assign rd_data = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= wr_data;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/wiegand26_decoder.sv
// wiegand26_decoder: parity-checks 26-bit Wiegand frames and queues good IDs; optional
// duplicate filter enabled by WIEGAND_DUP_FILTER_EN.
module wiegand26_decoder
  import wiegand_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int HOLDOFF_CYC = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WG_FRAME_W-1:0]   wg_data,
  input  logic                    wg_int,
  input  logic                    rd_en,
  input  logic                    clr,
  output logic [WG_ID_W-1:0]      rd_data,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic [7:0]              err_cnt,
  output logic                    ovf
);
  logic s1, s2, e_q, evt, frame_v, res_v, res_good, full, dup, good, bad;
  logic [WG_FRAME_W-1:0] frame_q;
  wg_id_t id_q;
  always_ff @(posedge clk)
    if (rst) begin
      {s1, s2, e_q} <= 3'b111;
      evt <= 1'b0;
      frame_v <= 1'b0;
      frame_q <= '0;
      res_v <= 1'b0;
      res_good <= 1'b0;
      id_q <= '0;
    end else begin
      s1 <= wg_int;
      s2 <= s1;
      e_q <= s2;
      evt <= s2 && !e_q;
      frame_v <= evt;
      if (evt) frame_q <= wg_data;
      res_v <= frame_v;
      res_good <= parity_ok(frame_q);
      id_q <= '{facility: frame_q[FAC_HI:FAC_LO], card: frame_q[CARD_HI:CARD_LO]};
    end
`ifdef WIEGAND_DUP_FILTER_EN
  localparam int HW = $clog2(HOLDOFF_CYC + 1);
  wg_id_t held;
  logic [HW-1:0] hold_cnt;
  assign dup = (held == id_q) && (hold_cnt != '0);
  always_ff @(posedge clk)
    if (rst) begin
      held <= '0;
      hold_cnt <= '0;
    end else if (res_v && res_good) begin
      held <= id_q;
      hold_cnt <= HW'(HOLDOFF_CYC);
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
`else
  assign dup = 1'b0;
`endif
  assign good = res_v && res_good && !dup;
  assign bad = res_v && !res_good;
  always_ff @(posedge clk)
    if (rst) begin
      err_cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      err_cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (bad && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
      if (good && full && !rd_en) ovf <= 1'b1;
    end
  wg_id_fifo #(.W(WG_ID_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(good),
    .wr_data(id_q),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .empty(empty),
    .full(full),
    .count(count)
  );
endmodule
